// File: rtl/axis_reg_writer_pkg.sv
// reg_writer_pkg: shared types, limits and the block-address one-hot decoder
package reg_writer_pkg;
  localparam int NREG_MAX   = 16;
  localparam int NBLOCK_MAX = 64;
  localparam int DATA_W     = 32;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE} state_e;
  function automatic logic [NBLOCK_MAX-1:0] onehot(input logic [5:0] idx);
    return {{(NBLOCK_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/axis_reg_writer_if.sv
// axis_reg_writer_if: AXI4-Stream data channel between a source and the register writer
interface axis_reg_writer_if;
  import reg_writer_pkg::*;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_reg_writer.sv
// axis_reg_writer: loads address-tagged blocks of NREG registers from a stream and pulses we[addr]
module axis_reg_writer
  import reg_writer_pkg::*;
#(
  parameter int NREG = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  axis_reg_writer_if.slave      s_axis,
  input  logic                  START_REG,
  output logic [NBLOCK_MAX-1:0] we,
  output logic [DATA_W-1:0]     reg00_out,
  output logic [DATA_W-1:0]     reg01_out,
  output logic [DATA_W-1:0]     reg02_out,
  output logic [DATA_W-1:0]     reg03_out,
  output logic [DATA_W-1:0]     reg04_out,
  output logic [DATA_W-1:0]     reg05_out,
  output logic [DATA_W-1:0]     reg06_out,
  output logic [DATA_W-1:0]     reg07_out,
  output logic [DATA_W-1:0]     reg08_out,
  output logic [DATA_W-1:0]     reg09_out,
  output logic [DATA_W-1:0]     reg10_out,
  output logic [DATA_W-1:0]     reg11_out,
  output logic [DATA_W-1:0]     reg12_out,
  output logic [DATA_W-1:0]     reg13_out,
  output logic [DATA_W-1:0]     reg14_out,
  output logic [DATA_W-1:0]     reg15_out
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] addr_q;
  logic              last_q;
  logic [DATA_W-1:0] staging_q [NREG_MAX];
  logic [DATA_W-1:0] regs_q [NREG_MAX];
  logic              beat, last_word, commit;
  assign beat      = s_axis.tvalid & s_axis.tready;
  assign last_word = cnt_q == 4'(NREG - 1);
  assign commit    = state_q == DATA && beat && START_REG && last_word;
  // state register
  always_ff @(posedge clk)
    state_q <= !rstn ? IDLE : state_d;
  // next state; dropping START_REG while collecting a block discards it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = START_REG ? ADDR : IDLE;
      ADDR:    state_d = !START_REG ? IDLE : !beat ? ADDR : s_axis.tlast ? DONE : DATA;
      DATA:    state_d = !START_REG ? IDLE : !beat ? DATA : last_word ? WRITE : s_axis.tlast ? DONE : DATA;
      WRITE:   state_d = last_q ? DONE : ADDR;
      DONE:    state_d = START_REG ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; tready drops in WRITE so a held stale word is not taken twice
  always_comb begin
    s_axis.tready = state_q == ADDR || state_q == DATA;
    we = (state_q == WRITE && addr_q < DATA_W'(NBLOCK_MAX)) ? onehot(addr_q[5:0]) : '0;
  end
  // address latch, staging buffer and parallel output load on the final data beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      staging_q <= '{default: '0};
      regs_q    <= '{default: '0};
    end else begin
      if (state_q == ADDR && beat) begin
        addr_q <= s_axis.tdata;
        cnt_q  <= '0;
      end
      if (state_q == DATA && beat) begin
        staging_q[cnt_q] <= s_axis.tdata;
        cnt_q            <= cnt_q + 4'd1;
        last_q           <= s_axis.tlast;
      end
      if (commit)
        for (int k = 0; k < NREG; k++)
          regs_q[k] <= (k == NREG - 1) ? s_axis.tdata : staging_q[k];
    end
  end
  assign reg00_out = regs_q[0];
  assign reg01_out = regs_q[1];
  assign reg02_out = regs_q[2];
  assign reg03_out = regs_q[3];
  assign reg04_out = regs_q[4];
  assign reg05_out = regs_q[5];
  assign reg06_out = regs_q[6];
  assign reg07_out = regs_q[7];
  assign reg08_out = regs_q[8];
  assign reg09_out = regs_q[9];
  assign reg10_out = regs_q[10];
  assign reg11_out = regs_q[11];
  assign reg12_out = regs_q[12];
  assign reg13_out = regs_q[13];
  assign reg14_out = regs_q[14];
  assign reg15_out = regs_q[15];
endmodule

// File: tb/tb_axis_reg_writer.sv
// tb_axis_reg_writer: directed vectors with hand-computed expectations for axis_reg_writer
module tb_axis_reg_writer;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [63:0] we;
  logic [31:0] r [16];
  logic [31:0] exp_r [16];
  logic [63:0] we_or;
  int          n_chk = 0, n_fail = 0, beats = 0, cyc = 0;
  axis_reg_writer_if s_axis();
  always #5 clk = ~clk;
  axis_reg_writer #(.NREG(10)) dut (
    .clk(clk), .rstn(rstn), .s_axis(s_axis), .START_REG(start), .we(we),
    .reg00_out(r[0]),  .reg01_out(r[1]),  .reg02_out(r[2]),  .reg03_out(r[3]),
    .reg04_out(r[4]),  .reg05_out(r[5]),  .reg06_out(r[6]),  .reg07_out(r[7]),
    .reg08_out(r[8]),  .reg09_out(r[9]),  .reg10_out(r[10]), .reg11_out(r[11]),
    .reg12_out(r[12]), .reg13_out(r[13]), .reg14_out(r[14]), .reg15_out(r[15])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    if (s_axis.tvalid && s_axis.tready) beats++;
    @(posedge clk);
    #1;
    cyc++;
    we_or |= we;
  endtask
  task automatic send_word(input logic [31:0] d, input logic l);
    logic acc = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = s_axis.tready;
      tick();
    end
    check("accept", {63'd0, acc}, 64'd1);
  endtask
  task automatic check_regs(input string tag);
    for (int k = 0; k < 16; k++) check($sformatf("%s_r%0d", tag, k), {32'd0, r[k]}, {32'd0, exp_r[k]});
  endtask
  task automatic send_block(input string tag, input logic [31:0] a, input logic [31:0] base,
                            input logic l, input logic gap, input logic [63:0] exp_we);
    send_word(a, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if (gap) begin
        s_axis.tvalid = 1'b0;
        tick();
      end
      send_word(base + 32'(j), l && j == 9);
    end
    for (int k = 0; k < 10; k++) exp_r[k] = base + 32'(k);
    check({tag, "_we"}, we, exp_we);
    check_regs(tag);
    tick();
    check({tag, "_we_off"}, we, 64'd0);
  endtask
  task automatic rearm();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rearm_tready", {63'd0, s_axis.tready}, 64'd1);
  endtask
  initial begin
    for (int k = 0; k < 16; k++) exp_r[k] = '0;
    rstn = 1'b0; start = 1'b0; we_or = '0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("rst_tready", {63'd0, s_axis.tready}, 64'd0);
    check("rst_we", we, 64'd0);
    check_regs("rst");
    start = 1'b1;
    tick();
    check("arm_tready", {63'd0, s_axis.tready}, 64'd1);
    send_block("single", 32'd3, 32'd30, 1'b1, 1'b0, 64'h8);
    check("done_tready", {63'd0, s_axis.tready}, 64'd0);
    tick();
    check("done_hold", {63'd0, s_axis.tready}, 64'd0);
    rearm();
    beats = 0; cyc = 0;
    for (int i = 0; i < 16; i++)
      send_block($sformatf("b2b%0d", i), 32'(i), 32'(10 * i), i == 15, 1'b0, 64'd1 << i);
    check("b2b_beats", 64'(beats), 64'd176);
    check("b2b_cycles", 64'(cyc), 64'd192);
    check("b2b_done", {63'd0, s_axis.tready}, 64'd0);
    rearm();
    cyc = 0;
    send_word(32'd5, 1'b0);
    for (int j = 0; j < 10; j++) begin
      s_axis.tvalid = 1'b0;
      tick();
      send_word(32'd500 + 32'(j), 1'b0);
    end
    for (int k = 0; k < 10; k++) exp_r[k] = 32'd500 + 32'(k);
    check("bp_cycles", 64'(cyc), 64'd21);
    check("bp_we", we, 64'h20);
    check_regs("bp");
    tick();
    check("bp_addr_tready", {63'd0, s_axis.tready}, 64'd1);
    we_or = '0;
    send_word(32'd7, 1'b0);
    for (int j = 0; j < 4; j++) send_word(32'd700 + 32'(j), 1'b0);
    start = 1'b0; s_axis.tvalid = 1'b0;
    tick();
    tick();
    check("abort_idle_tready", {63'd0, s_axis.tready}, 64'd0);
    check("abort_we", we_or, 64'd0);
    check_regs("abort");
    start = 1'b1;
    tick();
    check("abort_rearm", {63'd0, s_axis.tready}, 64'd1);
    send_word(32'd8, 1'b0);
    for (int j = 0; j < 5; j++) send_word(32'd800 + 32'(j), j == 4);
    check("tlast_early_tready", {63'd0, s_axis.tready}, 64'd0);
    tick();
    check("tlast_early_hold", {63'd0, s_axis.tready}, 64'd0);
    check("tlast_early_we", we_or, 64'd0);
    check_regs("tlast_early");
    rearm();
    send_block("addr70", 32'd70, 32'd900, 1'b0, 1'b0, 64'd0);
    send_block("addr63", 32'd63, 32'd1000, 1'b1, 1'b0, 64'h8000_0000_0000_0000);
    check("a63_done", {63'd0, s_axis.tready}, 64'd0);
    rearm();
    send_word(32'd9, 1'b0);
    for (int j = 0; j < 3; j++) send_word(32'd1100 + 32'(j), 1'b0);
    rstn = 1'b0; s_axis.tvalid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) exp_r[k] = '0;
    check("midrst_tready", {63'd0, s_axis.tready}, 64'd0);
    check("midrst_we", we, 64'd0);
    check_regs("midrst");
    rstn = 1'b1; start = 1'b0;
    tick();
    check("midrst_idle", {63'd0, s_axis.tready}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_reg_writer.md
Name: axis_reg_writer

Overview:
- AXI4-Stream slave that loads blocks of NREG 32-bit configuration registers.
- Each block frame is one address word followed by NREG data words; tlast marks the final word of the whole transfer.
- When a block completes, all data words are presented in parallel on reg00_out..reg15_out and a one-cycle write-enable pulse is raised on we[address].
- Sits between a DMA/stream source and up to 64 register-block consumers, such as signal-generator parameter tables.

Parameters:
- NREG, 10, registers per block; legal range 1..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tdata  in  32  address word or register data.
- s_axis_tlast  in  1  last word of the whole transfer.
- we  out  64  one-hot write-enable pulse, indexed by block address.
- reg00_out..reg15_out  out  32 each  register values of the most recently completed block.
- START_REG  in  1  enable; level-sensitive.

Behaviour:
- Reset (rstn=0 at a clock edge) forces:
  - state IDLE, tready=0, we=0, all regNN_out=0.
  - staging buffer and address cleared.
- Beat = s_axis_tvalid & s_axis_tready at a rising edge. tready is a combinational decode of the state only.
- States:
  - IDLE: tready=0. Go to ADDR when START_REG=1.
  - ADDR: tready=1. On a beat, latch tdata[31:0] as the block address and go to DATA; data counter = 0.
  - DATA: tready=1. On each beat, store tdata in staging[cnt] and increment cnt. On the beat with cnt==NREG-1, load all outputs in the same edge (regK_out <= staging[K] for K<NREG-1; reg(NREG-1)_out <= tdata) and go to WRITE.
  - WRITE: exactly one cycle. tready=0; we[addr]=1 only if addr<64, otherwise we=0. Next state is DONE if tlast was set on the final data beat, else ADDR.
  - DONE: tready=0, we=0. Stay until START_REG=0, then go to IDLE. Re-arming requires START_REG 0->1.
- Latency and timing:
  - Outputs and we change together; both are visible in the cycle after the last data beat.
  - we is high for exactly 1 cycle.
  - Outputs hold their value until the next completed block.
- The tready=0 cycle in WRITE is mandatory: a source that holds tvalid high with stale data between blocks must not be double-accepted.
- regNN_out with index >= NREG: always 0.
- Back-to-back blocks: sustained rate is NREG+2 cycles per block (address beat, NREG data beats, WRITE).
- tlast on the address beat, or on any data beat other than the last: abort the block. No output update, no we; go to DONE.
- START_REG=0 in ADDR or DATA: abort to IDLE. The partial block is discarded, no we, outputs unchanged.
- Reset mid-block: immediate return to the reset state.
- tvalid=0 in ADDR or DATA: hold state and counter, no timeout.
- Upper address bits [31:6] are ignored only in the sense that addr>=64 suppresses we; data is still loaded to the outputs.

Decomposition:
- Shared package reg_writer_pkg:
  - state enum (IDLE, ADDR, DATA, WRITE, DONE).
  - constants NREG_MAX=16, NBLOCK_MAX=64, DATA_W=32.
- Single module; no sub-module needed. An optional one-hot decoder function goes in the package.

Test Plan:
- Reset/idle: rstn=0 then 1 with START_REG=0 -> tready=0, we=0, all regs 0. Raise START_REG -> tready=1 on the next cycle.
- Single block: NREG=10; stream addr=3, data 30..39, tlast on 39 -> next cycle we=64'h8 for 1 cycle, reg00..reg09=30..39, reg10..reg15=0. Then DONE with tready=0 even though tvalid is still 1.
- 16 back-to-back blocks, tvalid held high continuously: block i has addr=i, data 10*i+j; tlast on data 159 -> 16 single-cycle we pulses on bits 0..15 in order, each with reg00..09 = 10*i..10*i+9. The stale repeated word during the WRITE cycle is not accepted (verify beat count = 176).
- Backpressure from the source: tvalid toggled 0/1 every other cycle during a block -> identical outputs; the we pulse is delayed accordingly.
- Abort cases:
  - Drop START_REG after 4 data words -> no we, outputs unchanged, state IDLE.
  - tlast on data word 5 -> no we, state DONE.
  - addr=70 with a full block -> outputs load, we=0.
- Re-arm: after DONE, START_REG 1->0->1 -> tready returns to 1; a new block addr=63 -> we[63] pulse.
